// File: rtl/agg_pkt_framer.sv
`timescale 1ns/1ps
// agg_pkt_framer
// Re-frames the aggregator's merged word stream (one header word followed by
// payload rows) into sop/eop-marked words and buffers them in a small output
// FIFO. Packets whose header length exceeds MAX_LEN are swallowed whole and
// reported with drop_pulse. Forwarded and dropped packets are counted.
//
// Ports:
//   clk        block clock
//   reset      asynchronous active-low reset
//   in_data    word from the aggregator (header or payload row)
//   in_valid   in_data valid
//   in_ready   framer can accept a word this cycle
//   out_data   framed word (registered FIFO head)
//   out_sop    out_data is a header word
//   out_eop    out_data is the last payload row
//   out_valid  out_data/out_sop/out_eop valid (FIFO not empty)
//   out_ready  downstream accepts the head word
//   drop_pulse one-cycle pulse per dropped packet
//   pkt_count  forwarded packets, wraps
//   drop_count dropped packets, wraps
module agg_pkt_framer #(
  parameter int                        DATA_WIDTH   = 256,
  parameter int                        LENGTH_WIDTH = 16,
  parameter logic [LENGTH_WIDTH-1:0]   MAX_LEN      = 16'h0400,
  parameter int                        FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  drop_pulse,
  output logic [15:0]           pkt_count,
  output logic [15:0]           drop_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = DATA_WIDTH + 2;
  localparam logic [LENGTH_WIDTH-1:0] ROW_ONE  = {{(LENGTH_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]           CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]           CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_HDR     = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DROP    = 2'd2
  } state_t;

  state_t                          state_q, state_d;
  logic [LENGTH_WIDTH-1:0]         row_cnt_q, row_cnt_d;
  logic [FIFO_DEPTH-1:0][EW-1:0]   ent_q, ent_d;
  logic [CW-1:0]                   count_q, count_d;
  logic                            out_valid_q, out_valid_d;
  logic                            drop_pulse_q, drop_pulse_d;
  logic [15:0]                     pkt_count_q, pkt_count_d;
  logic [15:0]                     drop_count_q, drop_count_d;

  logic                            full_s;
  logic                            in_fire_s;
  logic                            pop_s;
  logic                            push_s;
  logic                            push_sop_s;
  logic                            push_eop_s;
  logic [LENGTH_WIDTH-1:0]         len_s;
  logic [LENGTH_WIDTH-1:0]         rows_s;
  logic [CW-1:0]                   wr_idx_s;
  logic [FIFO_DEPTH:0][EW-1:0]     ext_s;

  // In DROP the words are discarded, so a full FIFO must not stall the input.
  assign full_s    = (count_q == CNT_FULL);
  assign in_ready  = reset & (~full_s | (state_q == ST_DROP));
  assign in_fire_s = in_valid & in_ready;
  assign pop_s     = (count_q != CNT_ZERO) & out_ready;
  assign len_s     = in_data[LENGTH_WIDTH-1:0];
  assign rows_s    = (len_s >> 3'd3) + ROW_ONE;

  assign out_data   = ent_q[0][DATA_WIDTH-1:0];
  assign out_eop    = ent_q[0][DATA_WIDTH];
  assign out_sop    = ent_q[0][DATA_WIDTH+1];
  assign out_valid  = out_valid_q;
  assign drop_pulse = drop_pulse_q;
  assign pkt_count  = pkt_count_q;
  assign drop_count = drop_count_q;

  // Framing FSM: header decode, row counting, push control and counters.
  always_comb begin
    state_d      = state_q;
    row_cnt_d    = row_cnt_q;
    push_s       = 1'b0;
    push_sop_s   = 1'b0;
    push_eop_s   = 1'b0;
    drop_pulse_d = 1'b0;
    pkt_count_d  = pkt_count_q;
    drop_count_d = drop_count_q;
    case (state_q)
      ST_HDR: begin
        if (in_fire_s) begin
          row_cnt_d = rows_s;
          if (len_s <= MAX_LEN) begin
            push_s     = 1'b1;
            push_sop_s = 1'b1;
            state_d    = ST_PAYLOAD;
          end else begin
            drop_pulse_d = 1'b1;
            drop_count_d = drop_count_q + 16'd1;
            state_d      = ST_DROP;
          end
        end else begin
          state_d = ST_HDR;
        end
      end
      ST_PAYLOAD: begin
        if (in_fire_s) begin
          push_s    = 1'b1;
          row_cnt_d = row_cnt_q - ROW_ONE;
          if (row_cnt_q == ROW_ONE) begin
            push_eop_s  = 1'b1;
            pkt_count_d = pkt_count_q + 16'd1;
            state_d     = ST_HDR;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end else begin
          state_d = ST_PAYLOAD;
        end
      end
      ST_DROP: begin
        if (in_fire_s) begin
          row_cnt_d = row_cnt_q - ROW_ONE;
          if (row_cnt_q == ROW_ONE) begin
            state_d = ST_HDR;
          end else begin
            state_d = ST_DROP;
          end
        end else begin
          state_d = ST_DROP;
        end
      end
      default: begin
        state_d = ST_HDR;
      end
    endcase
  end

  // Shift-register FIFO: entry 0 is the registered head seen on the outputs.
  // A pop shifts live entries down; a push lands just above the surviving
  // entries. Entry 0 is left untouched when the last word pops, so out_data
  // holds its value while empty.
  always_comb begin
    ext_s    = {{EW{1'b0}}, ent_q};
    wr_idx_s = count_q - {{(CW-1){1'b0}}, pop_s};
    ent_d    = ent_q;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (push_s && (wr_idx_s == CW'(i))) begin
        ent_d[i] = {push_sop_s, push_eop_s, in_data};
      end else if (pop_s && (CW'(i + 1) < count_q)) begin
        ent_d[i] = ext_s[i+1];
      end else begin
        ent_d[i] = ent_q[i];
      end
    end
    count_d     = count_q + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};
    out_valid_d = (count_d != CNT_ZERO);
  end

  // State, FIFO and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_HDR;
      row_cnt_q    <= {LENGTH_WIDTH{1'b0}};
      ent_q        <= {(FIFO_DEPTH*EW){1'b0}};
      count_q      <= CNT_ZERO;
      out_valid_q  <= 1'b0;
      drop_pulse_q <= 1'b0;
      pkt_count_q  <= 16'd0;
      drop_count_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      row_cnt_q    <= row_cnt_d;
      ent_q        <= ent_d;
      count_q      <= count_d;
      out_valid_q  <= out_valid_d;
      drop_pulse_q <= drop_pulse_d;
      pkt_count_q  <= pkt_count_d;
      drop_count_q <= drop_count_d;
    end
  end

endmodule

// File: tb/tb_agg_pkt_framer.sv
`timescale 1ns/1ps
module tb_agg_pkt_framer;
  localparam int DW = 256;

  logic          clk;
  logic          reset;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_sop;
  logic          out_eop;
  logic          out_valid;
  logic          out_ready;
  logic          drop_pulse;
  logic [15:0]   pkt_count;
  logic [15:0]   drop_count;

  int checks = 0;
  int errors = 0;

  agg_pkt_framer #(
    .DATA_WIDTH(256), .LENGTH_WIDTH(16), .MAX_LEN(16'h0400), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_sop(out_sop),
    .out_eop(out_eop), .out_valid(out_valid), .out_ready(out_ready),
    .drop_pulse(drop_pulse), .pkt_count(pkt_count), .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] hdr_w(input logic [7:0] tag, input logic [15:0] len);
    hdr_w = {{30{tag}}, len};
  endfunction

  function automatic logic [DW-1:0] row_w(input logic [7:0] tag);
    row_w = {32{tag}};
  endfunction

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #12;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if ({out_valid, out_sop, out_eop, drop_pulse} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got v=%b sop=%b eop=%b drop=%b expected all 0", out_valid, out_sop, out_eop, drop_pulse); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    checks++; if ({pkt_count, drop_count} !== 32'd0) begin errors++; $display("FAIL reset_counters: got pkt=%h drop=%h expected 0", pkt_count, drop_count); end
    @(negedge clk);
    reset = 1'b1;
    cyc();
    checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL reset_release: got rdy=%b v=%b expected rdy=1 v=0", in_ready, out_valid); end
  endtask

  task automatic test_single();
    logic [DW-1:0] w [4];
    logic [1:0]    m [4];
    w[0] = hdr_w(8'h11, 16'd16); w[1] = row_w(8'h21); w[2] = row_w(8'h22); w[3] = row_w(8'h23);
    m = '{2'b10, 2'b00, 2'b00, 2'b01};
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = w[k];
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_ready%0d: got %b expected 1", k, in_ready); end
      cyc();
      checks++; if ({out_valid, out_sop, out_eop, out_data} !== {1'b1, m[k], w[k]}) begin errors++; $display("FAIL single_word%0d: got v=%b se=%b%b d=%h expected v=1 se=%b d=%h", k, out_valid, out_sop, out_eop, out_data, m[k], w[k]); end
    end
    in_valid = 1'b0;
    checks++; if (pkt_count !== 16'd1) begin errors++; $display("FAIL single_pkt_count: got %0d expected 1", pkt_count); end
    cyc();
    checks++; if ({out_valid, out_data} !== {1'b0, w[3]}) begin errors++; $display("FAIL single_empty_hold: got v=%b d=%h expected v=0 d=%h", out_valid, out_data, w[3]); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] w [4];
    logic [1:0]    m [4];
    w[0] = hdr_w(8'h31, 16'd0); w[1] = row_w(8'h32); w[2] = hdr_w(8'h33, 16'd0); w[3] = row_w(8'h34);
    m = '{2'b10, 2'b01, 2'b10, 2'b01};
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = w[k];
      cyc();
      checks++; if ({out_valid, out_sop, out_eop, out_data} !== {1'b1, m[k], w[k]}) begin errors++; $display("FAIL b2b_word%0d: got v=%b se=%b%b d=%h expected v=1 se=%b d=%h", k, out_valid, out_sop, out_eop, out_data, m[k], w[k]); end
    end
    in_valid = 1'b0;
    checks++; if (pkt_count !== 16'd3) begin errors++; $display("FAIL b2b_pkt_count: got %0d expected 3", pkt_count); end
    cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got v=%b expected 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] w [7];
    logic [1:0]    m [7];
    int idx;
    int n;
    logic fire;
    w[0] = hdr_w(8'h41, 16'd40);
    m[0] = 2'b10;
    for (int j = 1; j < 7; j++) begin
      w[j] = row_w(8'h41 + 8'(j));
      m[j] = (j == 6) ? 2'b01 : 2'b00;
    end
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1; in_data = w[idx];
      fire = in_ready;
      cyc();
      if (fire) idx++;
    end
    checks++; if (idx !== 4) begin errors++; $display("FAIL bp_accepted: got %0d words expected 4", idx); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b expected 0", in_ready); end
    checks++; if ({out_valid, out_sop, out_eop, out_data} !== {1'b1, m[0], w[0]}) begin errors++; $display("FAIL bp_head_hold: got v=%b se=%b%b d=%h expected v=1 se=10 d=%h", out_valid, out_sop, out_eop, out_data, w[0]); end
    out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 16; c++) begin
      if (out_valid) begin
        checks++;
        if (n >= 7) begin
          errors++; $display("FAIL bp_extra_word: got word %0d d=%h expected only 7 words", n, out_data);
        end else if ({out_sop, out_eop, out_data} !== {m[n], w[n]}) begin
          errors++; $display("FAIL bp_word%0d: got se=%b%b d=%h expected se=%b d=%h", n, out_sop, out_eop, out_data, m[n], w[n]);
        end
        n++;
      end
      if (idx < 7) begin in_valid = 1'b1; in_data = w[idx]; end
      else in_valid = 1'b0;
      fire = in_valid & in_ready;
      cyc();
      if (fire) idx++;
    end
    in_valid = 1'b0;
    checks++; if (n !== 7 || idx !== 7) begin errors++; $display("FAIL bp_totals: got out=%0d in=%0d expected 7 and 7", n, idx); end
    checks++; if (pkt_count !== 16'd4) begin errors++; $display("FAIL bp_pkt_count: got %0d expected 4", pkt_count); end
  endtask

  task automatic test_drop();
    logic [DW-1:0] w [3];
    logic [1:0]    m [3];
    int bad_ready;
    int bad_valid;
    int pulses;
    logic first_pulse;
    out_ready = 1'b0;
    bad_ready = 0; bad_valid = 0; pulses = 0; first_pulse = 1'b0;
    for (int k = 0; k < 258; k++) begin
      in_valid = 1'b1;
      in_data  = (k == 0) ? hdr_w(8'h51, 16'h0800) : row_w(8'h52);
      if (in_ready !== 1'b1) bad_ready++;
      if (out_valid !== 1'b0) bad_valid++;
      cyc();
      if (drop_pulse === 1'b1) pulses++;
      if (k == 0) first_pulse = drop_pulse;
    end
    in_valid = 1'b0;
    cyc();
    if (drop_pulse === 1'b1) pulses++;
    if (out_valid !== 1'b0) bad_valid++;
    checks++; if (bad_ready !== 0) begin errors++; $display("FAIL drop_in_ready: got %0d stalled cycles expected 0", bad_ready); end
    checks++; if (bad_valid !== 0) begin errors++; $display("FAIL drop_no_output: got %0d valid cycles expected 0", bad_valid); end
    checks++; if (first_pulse !== 1'b1) begin errors++; $display("FAIL drop_pulse_timing: got %b after header expected 1", first_pulse); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL drop_pulse_count: got %0d expected 1", pulses); end
    checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL drop_count: got %0d expected 1", drop_count); end
    w[0] = hdr_w(8'h55, 16'd8); w[1] = row_w(8'h56); w[2] = row_w(8'h57);
    m = '{2'b10, 2'b00, 2'b01};
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = w[k];
      cyc();
      checks++; if ({out_valid, out_sop, out_eop, out_data} !== {1'b1, m[k], w[k]}) begin errors++; $display("FAIL post_drop_word%0d: got v=%b se=%b%b d=%h expected v=1 se=%b d=%h", k, out_valid, out_sop, out_eop, out_data, m[k], w[k]); end
    end
    in_valid = 1'b0;
    checks++; if ({pkt_count, drop_count} !== {16'd5, 16'd1}) begin errors++; $display("FAIL post_drop_counts: got pkt=%0d drop=%0d expected 5 and 1", pkt_count, drop_count); end
    cyc();
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] w [2];
    logic [1:0]    m [2];
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = hdr_w(8'h61, 16'd24);
    cyc();
    in_data = row_w(8'h62);
    cyc();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: got v=%b expected 1", out_valid); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if ({out_valid, in_ready, out_sop} !== 3'b000) begin errors++; $display("FAIL rst_mid_flags: got v=%b rdy=%b sop=%b expected 0", out_valid, in_ready, out_sop); end
    checks++; if ({pkt_count, drop_count} !== 32'd0 || out_data !== '0) begin errors++; $display("FAIL rst_mid_clear: got pkt=%0d drop=%0d d=%h expected 0", pkt_count, drop_count, out_data); end
    @(negedge clk);
    reset = 1'b1;
    w[0] = hdr_w(8'h63, 16'd0); w[1] = row_w(8'h64);
    m = '{2'b10, 2'b01};
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_data = w[k];
      cyc();
      checks++; if ({out_valid, out_sop, out_eop, out_data} !== {1'b1, m[k], w[k]}) begin errors++; $display("FAIL rst_mid_word%0d: got v=%b se=%b%b d=%h expected v=1 se=%b d=%h", k, out_valid, out_sop, out_eop, out_data, m[k], w[k]); end
    end
    in_valid = 1'b0;
    checks++; if (pkt_count !== 16'd1) begin errors++; $display("FAIL rst_mid_pkt_count: got %0d expected 1", pkt_count); end
    cyc();
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    force dut.pkt_count_q = 16'hFFFE;
    #1;
    release dut.pkt_count_q;
    #1;
    checks++; if (pkt_count !== 16'hFFFE) begin errors++; $display("FAIL wrap_preload: got %h expected fffe", pkt_count); end
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = (k % 2 == 0) ? hdr_w(8'h71 + 8'(k), 16'd0) : row_w(8'h71 + 8'(k));
      cyc();
      if (k == 1) begin
        checks++; if (pkt_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff: got %h expected ffff", pkt_count); end
      end
      if (k == 3) begin
        checks++; if (pkt_count !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %h expected 0000", pkt_count); end
      end
    end
    in_valid = 1'b0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_drop();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
